l2_storage_bank: RTL and testbench



---
 rtl/l2_storage_bank.sv | 100 ++++++++++
 tb/tb_l2_storage_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/l2_storage_bank.sv
// l2_storage_bank: storage primitives for the L2 datapath.
// It holds a per-set metadata array, a byte-enabled line data array, and a
// full-line holding register that buffers fill data from memory.
// There is no handshake. Every read, write and load completes on the rising
// edge where its enable is sampled high. Reads return a registered value one
// edge later, and same-index reads forward the data being written.
module l2_storage_bank #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int width    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        meta_read,
  input  logic                        meta_load,
  input  logic [s_index-1:0]          meta_rindex,
  input  logic [s_index-1:0]          meta_windex,
  input  logic [width-1:0]            meta_datain,
  output logic [width-1:0]            meta_dataout,
  input  logic                        data_read,
  input  logic [2**s_offset-1:0]      data_write_en,
  input  logic [s_index-1:0]          data_rindex,
  input  logic [s_index-1:0]          data_windex,
  input  logic [8*2**s_offset-1:0]    data_datain,
  output logic [8*2**s_offset-1:0]    data_dataout,
  input  logic                        buf_load,
  input  logic [8*2**s_offset-1:0]    buf_in,
  output logic [8*2**s_offset-1:0]    buf_out
);

  localparam int num_sets  = 2**s_index;
  localparam int num_bytes = 2**s_offset;
  localparam int line_w    = 8*num_bytes;

  logic [width-1:0]  meta_mem [num_sets];
  logic [line_w-1:0] data_mem [num_sets];
  logic [line_w-1:0] data_fwd;

  // Metadata array write and registered read, with write-through forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < num_sets; i++) begin
        meta_mem[i] <= '0;
      end
      meta_dataout <= '0;
    end else begin
      if (meta_load) begin
        meta_mem[meta_windex] <= meta_datain;
      end
      if (meta_read) begin
        if (meta_load && (meta_rindex == meta_windex)) begin
          meta_dataout <= meta_datain;
        end else begin
          meta_dataout <= meta_mem[meta_rindex];
        end
      end
    end
  end

  // Line read value: the stored line with the bytes written this cycle merged in
  always_comb begin
    data_fwd = data_mem[data_rindex];
    if (data_rindex == data_windex) begin
      for (int b = 0; b < num_bytes; b++) begin
        if (data_write_en[b]) begin
          data_fwd[8*b +: 8] = data_datain[8*b +: 8];
        end
      end
    end
  end

  // Data array byte-enabled write and registered line read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < num_sets; i++) begin
        data_mem[i] <= '0;
      end
      data_dataout <= '0;
    end else begin
      for (int b = 0; b < num_bytes; b++) begin
        if (data_write_en[b]) begin
          data_mem[data_windex][8*b +: 8] <= data_datain[8*b +: 8];
        end
      end
      if (data_read) begin
        data_dataout <= data_fwd;
      end
    end
  end

  // Holding register for memory fill data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_out <= '0;
    end else if (buf_load) begin
      buf_out <= buf_in;
    end
  end

endmodule

// File: tb/tb_l2_storage_bank.sv
// Directed testbench for l2_storage_bank, instantiated with a 24-bit
// metadata width (tag-array configuration).
module tb_l2_storage_bank;

  localparam int s_offset = 5;
  localparam int s_index  = 3;
  localparam int width    = 24;
  localparam int line_w   = 8*2**s_offset;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   meta_read = 1'b0;
  logic                   meta_load = 1'b0;
  logic [s_index-1:0]     meta_rindex = '0;
  logic [s_index-1:0]     meta_windex = '0;
  logic [width-1:0]       meta_datain = '0;
  logic [width-1:0]       meta_dataout;
  logic                   data_read = 1'b0;
  logic [2**s_offset-1:0] data_write_en = '0;
  logic [s_index-1:0]     data_rindex = '0;
  logic [s_index-1:0]     data_windex = '0;
  logic [line_w-1:0]      data_datain = '0;
  logic [line_w-1:0]      data_dataout;
  logic                   buf_load = 1'b0;
  logic [line_w-1:0]      buf_in = '0;
  logic [line_w-1:0]      buf_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [line_w-1:0] pat_p;
  logic [line_w-1:0] held;

  l2_storage_bank #(
    .s_offset(s_offset),
    .s_index (s_index),
    .width   (width)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .meta_read    (meta_read),
    .meta_load    (meta_load),
    .meta_rindex  (meta_rindex),
    .meta_windex  (meta_windex),
    .meta_datain  (meta_datain),
    .meta_dataout (meta_dataout),
    .data_read    (data_read),
    .data_write_en(data_write_en),
    .data_rindex  (data_rindex),
    .data_windex  (data_windex),
    .data_datain  (data_datain),
    .data_dataout (data_dataout),
    .buf_load     (buf_load),
    .buf_in       (buf_in),
    .buf_out      (buf_out)
  );

  // Advance one rising edge, then settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [line_w-1:0] obs,
                     input logic [line_w-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_meta(input string tag, input logic [width-1:0] exp);
    chk(tag, line_w'(meta_dataout), line_w'(exp));
  endtask

  initial begin
    pat_p = {8{32'hDEADBEEF}};

    // Hold reset for two edges, then release mid-cycle
    step();
    step();
    chk_meta("rst_meta_out", 24'h0);
    chk("rst_data_out", data_dataout, '0);
    chk("rst_buf_out", buf_out, '0);
    rst = 1'b0;

    // Fill meta set 3, data line 5 and buf with reads forwarded in the same cycle
    meta_load = 1'b1; meta_windex = 3'd3; meta_datain = 24'h000001;
    meta_read = 1'b1; meta_rindex = 3'd3;
    data_write_en = '1; data_windex = 3'd5; data_datain = {32{8'hAA}};
    data_read = 1'b1; data_rindex = 3'd5;
    buf_load = 1'b1; buf_in = '1;
    step();
    meta_load = 1'b0; data_write_en = '0; buf_load = 1'b0;
    meta_read = 1'b0; data_read = 1'b0;
    chk_meta("pre_rst_meta", 24'h000001);
    chk("pre_rst_data", data_dataout, {32{8'hAA}});
    chk("pre_rst_buf", buf_out, '1);

    // Asynchronous reset between edges clears the outputs at once
    #2 rst = 1'b1;
    #1;
    chk_meta("async_rst_meta", 24'h0);
    chk("async_rst_data", data_dataout, '0);
    chk("async_rst_buf", buf_out, '0);
    #1 rst = 1'b0;

    // After release, the arrays read back as zero
    meta_read = 1'b1; meta_rindex = 3'd3;
    data_read = 1'b1; data_rindex = 3'd5;
    step();
    chk_meta("post_rst_meta_set3", 24'h0);
    chk("post_rst_data_set5", data_dataout, '0);

    // 24-bit metadata load of set 2 with same-cycle forwarded read
    meta_load = 1'b1; meta_windex = 3'd2; meta_datain = 24'hABCDEF;
    meta_rindex = 3'd2;
    step();
    meta_load = 1'b0;
    chk_meta("meta_fwd_set2", 24'hABCDEF);
    meta_rindex = 3'd1;
    step();
    chk_meta("meta_set1_zero", 24'h0);
    meta_rindex = 3'd2;
    step();
    chk_meta("meta_set2_stored", 24'hABCDEF);
    // With meta_read low the output holds even though the index changes
    meta_read = 1'b0; meta_rindex = 3'd1;
    step();
    chk_meta("meta_hold", 24'hABCDEF);

    // Byte enables on line 4
    data_read = 1'b0;
    data_write_en = '1; data_windex = 3'd4; data_datain = {32{8'h11}};
    step();
    data_write_en = 32'h0000000F; data_datain = {32{8'h22}};
    step();
    data_write_en = '0; data_read = 1'b1; data_rindex = 3'd4;
    step();
    chk("byte_en_line4", data_dataout, {{28{8'h11}}, {4{8'h22}}});
    // Per-byte forwarding: bytes 4-7 written while line 4 is read
    data_write_en = 32'h000000F0; data_windex = 3'd4; data_datain = {32{8'h33}};
    step();
    data_write_en = '0;
    chk("byte_fwd_line4", data_dataout, {{24{8'h11}}, {4{8'h33}}, {4{8'h22}}});
    step();
    chk("byte_stored_line4", data_dataout, {{24{8'h11}}, {4{8'h33}}, {4{8'h22}}});

    // Read hold while line 0 is written and the read index moves
    held = data_dataout;
    data_read = 1'b0;
    data_write_en = '1; data_windex = 3'd0; data_datain = {32{8'h55}};
    data_rindex = 3'd0;
    step();
    chk("data_hold", data_dataout, held);
    // An all-zero write enable leaves line 0 untouched
    data_write_en = '0; data_datain = {32{8'hEE}};
    data_read = 1'b1;
    step();
    chk("data_line0_after_read", data_dataout, {32{8'h55}});

    // Write set 6 and read set 7 in the same cycle
    data_read = 1'b0;
    data_write_en = '1; data_windex = 3'd7; data_datain = {32{8'h77}};
    step();
    data_windex = 3'd6; data_datain = {32{8'h66}};
    data_read = 1'b1; data_rindex = 3'd7;
    step();
    data_write_en = '0;
    chk("diff_idx_read7", data_dataout, {32{8'h77}});
    data_rindex = 3'd6;
    step();
    chk("diff_idx_set6", data_dataout, {32{8'h66}});

    // Holding register load and hold
    buf_load = 1'b1; buf_in = pat_p;
    step();
    chk("buf_load_p", buf_out, pat_p);
    buf_load = 1'b0; buf_in = ~pat_p;
    step();
    chk("buf_hold_1", buf_out, pat_p);
    buf_in = {8{$urandom_range(32'hFFFF_FFFF, 0)}};
    step();
    chk("buf_hold_2", buf_out, pat_p);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
